tile_packer: RTL and testbench

TILE_PACKER -- requirements
Module: tile_packer

---
 rtl/accelerator_config_pkg.sv | 15 +
 rtl/tile_packer.sv | 158 +++++++++++++++
 tb/tb_tile_packer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/accelerator_config_pkg.sv
// Shared accelerator configuration: element/tile geometry and the tile packer state encoding.
package accelerator_config_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int TILE_ELEMS = 4;
  localparam int TILE_WIDTH = DATA_WIDTH * TILE_ELEMS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } tile_packer_state_t;

endpackage

// File: rtl/tile_packer.sv
// Packs a stream of elements into tiles and writes each tile to a selected buffer.
// Build option TILE_PACKER_ZERO_PAD_EN: clear unfilled lanes of a final partial tile.
//
// state | meaning
// IDLE  | waiting for start
// FILL  | accepting elements into the current tile
// FLUSH | tile write strobe, no elements accepted
// DONE  | one-cycle completion pulse
module tile_packer #(
  parameter int DATA_WIDTH   = accelerator_config_pkg::DATA_WIDTH,
  parameter int TILE_ELEMS   = accelerator_config_pkg::TILE_ELEMS,
  parameter int BUFFER_COUNT = 2,
  parameter int LEN_WIDTH    = 16,
  localparam int BUF_W       = (BUFFER_COUNT > 1) ? $clog2(BUFFER_COUNT) : 1,
  localparam int TILE_W      = TILE_ELEMS * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BUF_W-1:0]      dest_buffer,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  write_enable,
  output logic [TILE_W-1:0]     write_data,
  output logic [BUF_W-1:0]      write_buffer,
  output logic                  reset_indices_enable,
  output logic [BUF_W-1:0]      reset_indices_buffer,
  output logic                  busy,
  output logic                  done
);

  import accelerator_config_pkg::*;

  localparam int LANE_W = (TILE_ELEMS > 1) ? $clog2(TILE_ELEMS) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(TILE_ELEMS - 1);

  tile_packer_state_t   r_state;
  tile_packer_state_t   w_state_next;
  logic [LEN_WIDTH-1:0] r_remaining;
  logic [LANE_W-1:0]    r_lane;
  logic [TILE_W-1:0]    r_tile;
  logic [TILE_W-1:0]    w_tile_next;
  logic [BUF_W-1:0]     r_buf;
  logic                 r_first;
  logic                 w_accept;
  logic                 w_tile_end;

  assign w_accept   = in_valid && in_ready;
  assign w_tile_end = (r_lane == LAST_LANE) || (r_remaining == LEN_WIDTH'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = (length != '0) ? ST_FILL : ST_DONE;
        end
      end
      ST_FILL: begin
        if (w_accept && w_tile_end) begin
          w_state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        w_state_next = (r_remaining != '0) ? ST_FILL : ST_DONE;
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    in_ready             = 1'b0;
    write_enable         = 1'b0;
    reset_indices_enable = 1'b0;
    busy                 = 1'b0;
    done                 = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
      end
      ST_FILL: begin
        busy     = 1'b1;
        in_ready = (r_remaining != '0);
      end
      ST_FLUSH: begin
        busy                 = 1'b1;
        write_enable         = 1'b1;
        reset_indices_enable = r_first;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Lane 0 of each tile optionally starts from a cleared tile; otherwise stale lanes persist.
  always_comb begin
    w_tile_next = r_tile;
`ifdef TILE_PACKER_ZERO_PAD_EN
    if (r_lane == '0) begin
      w_tile_next = '0;
    end
`endif
    w_tile_next[int'(r_lane)*DATA_WIDTH +: DATA_WIDTH] = in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_remaining <= '0;
      r_lane      <= '0;
      r_tile      <= '0;
      r_buf       <= '0;
      r_first     <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && start) begin
        r_remaining <= length;
        r_buf       <= dest_buffer;
        r_lane      <= '0;
        r_first     <= 1'b1;
      end
      if (w_accept) begin
        r_tile <= w_tile_next;
        if (r_remaining != '0) begin
          r_remaining <= r_remaining - 1'b1;
        end
        r_lane <= (r_lane == LAST_LANE) ? '0 : r_lane + 1'b1;
      end
      if (r_state == ST_FLUSH) begin
        r_first <= 1'b0;
        r_lane  <= '0;
      end
    end
  end

  assign write_data           = r_tile;
  assign write_buffer         = r_buf;
  assign reset_indices_buffer = r_buf;

endmodule

// File: tb/tb_tile_packer.sv
// Randomized scoreboard bench for tile_packer; honours TILE_PACKER_ZERO_PAD_EN in its model.
module tb_tile_packer;
  import accelerator_config_pkg::*;

  localparam int DW = 8;
  localparam int TE = 4;
  localparam int TW = DW * TE;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [0:0]    dest_buffer = 1'b0;
  logic [15:0]   length = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          write_enable;
  logic [TW-1:0] write_data;
  logic [0:0]    write_buffer;
  logic          reset_indices_enable;
  logic [0:0]    reset_indices_buffer;
  logic          busy;
  logic          done;

  tile_packer #(
    .DATA_WIDTH(DW), .TILE_ELEMS(TE), .BUFFER_COUNT(2), .LEN_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .dest_buffer(dest_buffer),
    .length(length), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .write_enable(write_enable), .write_data(write_data), .write_buffer(write_buffer),
    .reset_indices_enable(reset_indices_enable),
    .reset_indices_buffer(reset_indices_buffer), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0] data;
    logic [0:0]    bufid;
    logic          first;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            done_cnt = 0;
  int            write_cnt = 0;
  logic [TW-1:0] m_tile = '0;

  bit m_active = 0, pend_write = 0, pend_done = 0, exp_busy = 0;
  int job_len = 0, hs_count = 0, w_left = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, expv, $time);
    end
  endtask

  // Scoreboard/monitor: samples on the falling edge, job timing derived from length and handshakes.
  always @(negedge clk) begin : mon
    bit   nw, nd, nb, hs;
    exp_t e;
    if (reset) begin
      check("reset_outputs", {in_ready, write_enable, reset_indices_enable, busy, done,
                              write_data, write_buffer, reset_indices_buffer}, '0);
      exp_q.delete();
      m_active = 0; pend_write = 0; pend_done = 0; exp_busy = 0;
      job_len = 0; hs_count = 0; w_left = 0;
    end else begin
      nw = 0; nd = 0; nb = exp_busy;
      check("busy", busy, exp_busy);
      check("write_timing", write_enable, pend_write);
      if (write_enable) begin
        write_cnt++;
        check("ready_in_flush", in_ready, 0);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write got=%0h exp=none", write_data);
        end else begin
          e = exp_q.pop_front();
          check("write_data", write_data, e.data);
          check("write_buffer", write_buffer, e.bufid);
          check("reset_indices_buffer", reset_indices_buffer, e.bufid);
          check("reset_indices_enable", reset_indices_enable, e.first);
        end
        if (w_left > 0) w_left--;
        if (w_left == 0) nd = 1;
      end else begin
        check("rst_idx_alone", reset_indices_enable, 0);
      end
      check("done", done, pend_done);
      hs = in_valid && in_ready;
      if (hs) begin
        check("extra_accept", (m_active && hs_count < job_len), 1);
        hs_count++;
        nw = (hs_count % TE == 0) || (hs_count == job_len);
      end
      if (start && !m_active) begin
        m_active = 1; job_len = int'(length); hs_count = 0;
        w_left = (job_len + TE - 1) / TE; nb = 1;
        if (job_len == 0) nd = 1;
      end
      if (done) begin
        done_cnt++; m_active = 0; nb = 0;
      end
      pend_write = nw; pend_done = nd; exp_busy = nb;
    end
  end

  // mode 0: back-to-back, 1: valid every other cycle, 2: random valid; base<0 gives random bytes.
  task automatic run_job(input int len, input int dest, input int mode, input int base,
                         input bit spurious);
    logic [DW-1:0] d[$];
    logic          first;
    int            idx, cyc, lane, d0;
    bit            hs;
    for (int k = 0; k < len; k++) d.push_back(base >= 0 ? DW'(base + k) : DW'($urandom));
    first = 1'b1;
    for (int k = 0; k < len; k++) begin
      lane = k % TE;
`ifdef TILE_PACKER_ZERO_PAD_EN
      if (lane == 0) m_tile = '0;
`endif
      m_tile[lane*DW +: DW] = d[k];
      if (lane == TE - 1 || k == len - 1) begin
        exp_q.push_back('{m_tile, 1'(dest), first});
        first = 1'b0;
      end
    end
    d0 = done_cnt;
    start = 1'b1; length = 16'(len); dest_buffer = 1'(dest);
    @(posedge clk); #1;
    start = spurious;
    if (spurious) begin
      length = 16'($urandom_range(1, 20));
      dest_buffer = ~dest_buffer;
    end
    idx = 0; cyc = 0;
    while (idx < len && cyc < 400) begin
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 2 == 0);
        default: in_valid = ($urandom_range(0, 9) < 7);
      endcase
      in_data = d[idx];
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) idx++;
      cyc++;
    end
    check("job_accepted", idx, len);
    in_valid = 1'b1; in_data = 8'hEE;
    cyc = 0;
    while (done_cnt == d0 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("job_done_seen", (done_cnt != d0), 1);
    in_valid = 1'b0; start = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int d0, w0, hsn, cyc;
    bit hs;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    run_job(8, 1, 0, 8'h01, 1'b0);
    run_job(6, 0, 0, 8'hA1, 1'b0);
    run_job(0, 1, 0, 0, 1'b0);
    run_job(4, 0, 1, 8'h10, 1'b0);
    run_job(7, 1, 2, -1, 1'b1);

    // Abandon a job after two elements.
    d0 = done_cnt; w0 = write_cnt;
    start = 1'b1; length = 16'd8; dest_buffer = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = 8'h55;
    hsn = 0; cyc = 0;
    while (hsn < 2 && cyc < 20) begin
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) hsn++;
      cyc++;
    end
    check("pre_reset_handshakes", hsn, 2);
    reset = 1'b1; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_tile = '0;
    repeat (12) @(posedge clk);
    #1;
    check("no_done_after_reset", done_cnt, d0);
    check("no_write_after_reset", write_cnt, w0);

    for (int j = 0; j < 25; j++) begin
      run_job($urandom_range(0, 13), $urandom_range(0, 1), $urandom_range(0, 2), -1,
              1'($urandom_range(0, 1)));
    end
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
